// File: rtl/imm_ext_pipe.sv
// Immediate extension unit with valid/ready handshake and a 2-entry output FIFO.
// Define IMM_EXT_ERR_EN to store a per-entry reserved-mode flag and a sticky error bit.
module imm_ext_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [2:0]           in_mode,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_err,
  output logic                 err_sticky
);

  localparam int unsigned ExtWidth = OUT_WIDTH - IN_WIDTH;

  localparam logic [2:0] ModeZero     = 3'd0;
  localparam logic [2:0] ModeSign     = 3'd1;
  localparam logic [2:0] ModeSignShl2 = 3'd2;
  localparam logic [2:0] ModeUpper    = 3'd3;
  localparam logic [2:0] ModeShamt    = 3'd4;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0] ext_data;
  logic                 ext_rsvd;

  logic [OUT_WIDTH-1:0] data0_q, data1_q;
  logic [TAG_WIDTH-1:0] tag0_q, tag1_q;

  logic push, pop;
  // Slot 0 is always the head; slot 1 only holds the second beat when full.
  logic load0, load1, shift;

  // ---------------------------------------------------------------------------
  // Extension datapath (combinational at the input)
  // ---------------------------------------------------------------------------
  assign sext = {{ExtWidth{in_imm[IN_WIDTH-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    ext_rsvd = 1'b0;
    case (in_mode)
      ModeZero:     ext_data = {{ExtWidth{1'b0}}, in_imm};
      ModeSign:     ext_data = sext;
      ModeSignShl2: ext_data = {sext[OUT_WIDTH-3:0], 2'b00};
      ModeUpper:    ext_data = {in_imm, {ExtWidth{1'b0}}};
      ModeShamt:    ext_data = {{(OUT_WIDTH-5){1'b0}}, in_imm[4:0]};
      default:      ext_rsvd = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and occupancy FSM
  // ---------------------------------------------------------------------------
  assign in_ready  = !rst && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    load1   = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          load0   = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          load0 = 1'b1;
        end else if (push) begin
          load1   = 1'b1;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          shift   = 1'b1;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      if (load0) begin
        data0_q <= ext_data;
        tag0_q  <= in_tag;
      end else if (shift) begin
        data0_q <= data1_q;
        tag0_q  <= tag1_q;
      end
      if (load1) begin
        data1_q <= ext_data;
        tag1_q  <= in_tag;
      end
    end
  end

  assign out_data = out_valid ? data0_q : '0;
  assign out_tag  = out_valid ? tag0_q  : '0;

  // ---------------------------------------------------------------------------
  // Reserved-mode error tracking
  // ---------------------------------------------------------------------------
`ifdef IMM_EXT_ERR_EN
  logic err0_q, err1_q;
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (load0) begin
        err0_q <= ext_rsvd;
      end else if (shift) begin
        err0_q <= err1_q;
      end
      if (load1) begin
        err1_q <= ext_rsvd;
      end
      if (push && ext_rsvd) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign out_err    = out_valid && err0_q;
  assign err_sticky = sticky_q;
`else
  logic unused_rsvd;
  assign unused_rsvd = ext_rsvd;
  assign out_err     = 1'b0;
  assign err_sticky  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // A stalled head must not change until it is popped.
  head_stable_a : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)));

  no_load_and_shift_a : assert property (@(posedge clk) disable iff (rst)
    !(load0 && shift));
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Randomized and directed bench for imm_ext_pipe against a queue-based reference model.
// Honours IMM_EXT_ERR_EN for out_err / err_sticky expectations.
module tb_imm_ext_pipe;

  localparam int IW = 16;
  localparam int OW = 32;
  localparam int TW = 5;

`ifdef IMM_EXT_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_imm = '0;
  logic [2:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic          err_sticky;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } beat_t;

  beat_t mq[$];
  logic  msticky = 1'b0;

  imm_ext_pipe #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Arithmetic reference: value of the immediate under each mode, modulo 2^32.
  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [2:0] mode);
    longint s;
    s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
    case (mode)
      3'd0:    return 32'(longint'(imm));
      3'd1:    return 32'(s);
      3'd2:    return 32'(s * 4);
      3'd3:    return 32'(longint'(imm) * 65536);
      3'd4:    return 32'(longint'(imm) % 32);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction
  function automatic logic [31:0] exp_data();
    return (mq.size() != 0) ? mq[0].data : 32'd0;
  endfunction
  function automatic logic [4:0] exp_tag();
    return (mq.size() != 0) ? mq[0].tag : 5'd0;
  endfunction
  function automatic logic exp_err();
    return (mq.size() != 0) ? mq[0].err : 1'b0;
  endfunction
  function automatic logic exp_ready();
    return !rst && (mq.size() < 2);
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    bit    push, pop;
    beat_t b;
    push   = !rst && in_valid && (mq.size() < 2);
    pop    = !rst && (mq.size() != 0) && out_ready;
    b.data = ref_ext(in_imm, in_mode);
    b.tag  = in_tag;
    b.err  = ErrEn && (in_mode >= 3'd5);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      msticky = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(b);
        if (b.err) msticky = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_imm = 16'h1234;
    in_mode = 3'd5;
    out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_beat: got %b want 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [15:0] imms[7]  = '{16'h8001, 16'h8001, 16'hFFFF, 16'h1234, 16'hFFE3, 16'h7FFF, 16'h8000};
    logic [2:0]  modes[7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3};
    logic [4:0]  tags[7]  = '{5'd7, 5'd3, 5'd9, 5'd11, 5'd21, 5'd2, 5'd30};
    logic [31:0] wants[7] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFFFC, 32'h12340000,
                              32'h00000003, 32'h00007FFF, 32'h80000000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_imm = imms[i];
      in_mode = modes[i];
      in_tag = tags[i];
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== wants[i]) begin n_fail++; $display("FAIL modes_data[%0d]: got %h want %h", i, out_data, wants[i]); end
      n_cmp++; if (out_tag !== tags[i]) begin n_fail++; $display("FAIL modes_tag[%0d]: got %0d want %0d", i, out_tag, tags[i]); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_drain[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reserved();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_imm = 16'hABCD;
    in_mode = 3'd5;
    in_tag = 5'd13;
    tick();
    n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rsvd_data: got %h want 0", out_data); end
    n_cmp++; if (out_err !== ErrEn) begin n_fail++; $display("FAIL rsvd_err: got %b want %b", out_err, ErrEn); end
    n_cmp++; if (err_sticky !== ErrEn) begin n_fail++; $display("FAIL rsvd_sticky: got %b want %b", err_sticky, ErrEn); end
    for (int i = 0; i < 3; i++) begin
      in_mode = 3'd0;
      in_imm = 16'($urandom);
      in_tag = 5'(i);
      tick();
      n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rsvd_later_err[%0d]: got %b want 0", i, out_err); end
      n_cmp++; if (err_sticky !== ErrEn) begin n_fail++; $display("FAIL rsvd_later_sticky[%0d]: got %b want %b", i, err_sticky, ErrEn); end
      n_cmp++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rsvd_later_data[%0d]: got %h want %h", i, out_data, exp_data()); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [4:0] got[$];
    int         nxt;
    int         gaps;
    bit         acc;
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      in_valid = 1'b1;
      in_tag = 5'(t);
      in_mode = 3'd0;
      in_imm = 16'($urandom);
      n_cmp++; if (in_ready !== (t <= 2)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", t, in_ready, (t <= 2)); end
      tick();
    end
    n_cmp++; if (out_tag !== 5'd1) begin n_fail++; $display("FAIL bp_head: got %0d want 1", out_tag); end
    out_ready = 1'b1;
    nxt = 3;
    in_tag = 5'd3;
    gaps = 0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      acc = in_valid && (mq.size() < 2);
      if (out_valid) got.push_back(out_tag);
      else gaps++;
      tick();
      if (acc) begin
        nxt++;
        if (nxt > 4) in_valid = 1'b0;
        else in_tag = 5'(nxt);
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats want 4", got.size()); end
    n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL bp_gaps: got %0d idle cycles want 0", gaps); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_tag = 5'(i);
      in_imm = 16'($urandom);
      in_mode = 3'($urandom_range(4, 0));
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      n_cmp++; if (out_tag !== 5'(i)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, out_tag, i); end
      n_cmp++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, exp_data()); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit hold;
    bit acc;
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(3, 0) != 0);
        in_imm = 16'($urandom);
        in_mode = 3'($urandom_range(7, 0));
        in_tag = 5'($urandom);
      end
      out_ready = ($urandom_range(2, 0) != 0);
      rst = ($urandom_range(59, 0) == 0);
      acc = !rst && in_valid && (mq.size() < 2);
      hold = in_valid && !acc;
      tick();
      n_cmp++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, exp_valid()); end
      n_cmp++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, out_data, exp_data()); end
      n_cmp++; if (out_tag !== exp_tag()) begin n_fail++; $display("FAIL rnd_tag[%0d]: got %0d want %0d", c, out_tag, exp_tag()); end
      n_cmp++; if (out_err !== exp_err()) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", c, out_err, exp_err()); end
      n_cmp++; if (err_sticky !== msticky) begin n_fail++; $display("FAIL rnd_sticky[%0d]: got %b want %b", c, err_sticky, msticky); end
      n_cmp++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, exp_ready()); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_imm = 16'($urandom);
      in_mode = 3'd5;
      in_tag = 5'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_tag !== 5'd20) begin n_fail++; $display("FAIL mid_head_tag: got %0d want 20", out_tag); end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_rst: got %b want 0", in_ready); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_sticky: got %b want 0", err_sticky); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

- Parametrised, mode-selectable immediate extension unit with a valid/ready handshake and a 2-entry output buffer.
- Replaces the fixed-width zero/sign/shift extenders in the 54-instruction CPU datapath.
- Sits between decode and execute. Produces one OUT_WIDTH operand per accepted beat, carrying a destination tag alongside.
- Tolerates execute-stage stalls without dropping or duplicating operands.

## Interface
- IN_WIDTH, 16, raw immediate width; legal range 5..OUT_WIDTH-2.
- OUT_WIDTH, 32, extended operand width.
- TAG_WIDTH, 5, sideband tag carried unchanged with each beat.
- Reset is synchronous and active-high; there is one clock.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_imm  input  IN_WIDTH  raw immediate field.
- in_mode  input  3  extension mode.
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_data  output  OUT_WIDTH  extended operand.
- out_tag  output  TAG_WIDTH  tag of the current output beat.
- out_err  output  1  current output beat came from a reserved mode.
- err_sticky  output  1  a reserved mode has been accepted since reset.

## Operation
- Modes:
  - 000 ZERO: zero-extend in_imm.
  - 001 SIGN: replicate in_imm[IN_WIDTH-1] into the upper bits.
  - 010 SIGN_SHL2: sign-extend, then shift left 2 with zero fill (branch offset).
  - 011 UPPER: place in_imm at bits [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH], zero below (lui).
  - 100 SHAMT: zero-extend in_imm[4:0] only.
  - 101..111 reserved: data = 0.
- Extension result is computed combinationally at the input.
- The result is written, with its tag and error flag, into a 2-entry FIFO (count 0..2).
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Unaccepted inputs are ignored entirely; the unit's state does not change.
- in_ready = !rst && (count != 2).
- out_valid = (count != 0).
- out_data, out_tag and out_err always show the head entry. They show 0 when count is 0.
- Count transitions:
  - Accept and pop in the same cycle: count unchanged. Old head leaves and the new entry is written behind it, or becomes the head if count was 1.
  - Accept only: count + 1.
  - Pop only: count - 1.
- At count 2, in_ready is low, so an accept cannot coincide with full. A pop at full frees a slot; in_ready rises the following cycle.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- Upstream must hold its inputs stable while in_valid is high and in_ready is low. Changes during that window are undefined upstream behaviour.

## Timing
- Reset values:
  - count = 0
  - out_valid = 0, out_data = 0, out_tag = 0, out_err = 0
  - err_sticky = 0
  - in_ready = 0 while rst is high, 1 the first cycle after.
- Latency: a beat accepted at edge N is visible on the outputs after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Stall: out_ready low absorbs at most 2 beats. in_ready falls in the cycle after the second accept.
- Reset mid-operation: all buffered entries are discarded. out_valid is 0 after the reset edge, regardless of out_ready.
- err_sticky is set on the edge that accepts a reserved-mode beat. Only rst clears it.

## Configuration
- Macro: IMM_EXT_ERR_EN.
- Defined:
  - out_err is stored per entry.
  - err_sticky is implemented as described above.
- Undefined:
  - Reserved modes still produce data 0.
  - out_err and err_sticky are tied to 0 and no error state is synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use the defaults IN_WIDTH=16, OUT_WIDTH=32.
- Basic modes: imm 0x8001, mode SIGN, tag 7, out_ready=1 -> next cycle out_data 0xFFFF8001, out_tag 7. Same imm with mode ZERO -> 0x00008001.
- Shift modes:
  - SIGN_SHL2 imm 0xFFFF -> 0xFFFFFFFC.
  - UPPER imm 0x1234 -> 0x12340000.
  - SHAMT imm 0xFFE3 -> 0x00000003.
- Back-pressure:
  - Setup: out_ready=0; offer 4 consecutive beats with tags 1..4.
  - While stalled: only tags 1 and 2 are accepted, and in_ready is 0 from the third cycle.
  - After out_ready=1: tags emerge 1,2,3,4 with no gaps or duplicates.
- Full-throughput: 16 back-to-back beats, out_ready=1 -> out_valid high 16 consecutive cycles, count never exceeds 1.
- Reserved mode with IMM_EXT_ERR_EN defined: mode 101, imm 0xABCD -> out_data 0, out_err 1 for that beat. err_sticky stays 1 through later valid beats until rst. Without the macro, the same stimulus gives out_err 0 and err_sticky 0.
- Reset mid-stall: count 2, rst for 1 cycle -> out_valid 0 next cycle, in_ready 1 the cycle after rst drops, and no stale beat appears afterward.
